// File: rtl/game_pkg.sv
// Shared definitions for the snake game: flow states, default timing and the
// direction encoding used by the input logic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    // 4 Hz at level 0 from the 25 MHz pixel clock
    localparam int DEF_BASE_PERIOD    = 6_250_000;
    localparam int DEF_MIN_PERIOD     = 1_562_500;
    localparam int DEF_STEP           = 312_500;
    localparam int DEF_FOOD_PER_LEVEL = 5;
    localparam int DEF_MAX_LEVEL      = 15;
    localparam int DEF_CNT_W          = 23;

endpackage

// File: rtl/game_tick_scheduler_timer.sv
// Loadable down-counter; expired is raised on the edge the count reaches zero
// and stays up until the next load.
module tick_timer #(
    parameter int CNT_W = 23
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            expired <= (load_val == '0);
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1))
                expired <= 1'b1;
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game-flow sequencer: issues game_tick, handshakes with the snake datapath,
// and tracks score and speed level.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int BASE_PERIOD    = DEF_BASE_PERIOD,
    parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int STEP           = DEF_STEP,
    parameter int FOOD_PER_LEVEL = DEF_FOOD_PER_LEVEL,
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       update_done,
    input  logic       collision,
    input  logic       food_eaten,
    output logic       game_tick,
    output logic       game_reset,
    output logic [1:0] state,
    output logic [3:0] level,
    output logic [7:0] score
);

    localparam int PW = CNT_W + 4;

    game_state_t      st, st_nxt;
    logic             busy, expired, ack, start_go, run, fire;
    logic [7:0]       food_cnt;
    logic [PW-1:0]    dec, period;
    logic [CNT_W-1:0] load_val;

    assign ack      = update_done && busy;
    assign start_go = (st == IDLE || st == OVER) && start_pulse;
    assign state    = st;

    // wide intermediate so a large level*STEP cannot wrap before the clamp
    assign dec      = PW'(level) * PW'(STEP);
    assign period   = (dec > PW'(BASE_PERIOD - MIN_PERIOD)) ? PW'(MIN_PERIOD)
                                                            : PW'(BASE_PERIOD) - dec;
    assign load_val = start_go ? CNT_W'(BASE_PERIOD - 1) : CNT_W'(period - PW'(1));

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        run    = 1'b0;
        fire   = 1'b0;
        case (st)
            IDLE, OVER: if (start_pulse) st_nxt = PLAY;
            PLAY: begin
                if (ack && collision) st_nxt = OVER;
                else if (pause_pulse) st_nxt = PAUSE;
            end
            PAUSE: begin
                if (ack && collision) st_nxt = OVER;
                else if (pause_pulse) st_nxt = PLAY;
            end
            default: st_nxt = IDLE;
        endcase
        // the timer only runs on cycles that stay in (or resume into) PLAY
        run  = (st_nxt == PLAY) && (st == PLAY || st == PAUSE);
        fire = run && expired && (!busy || update_done);
    end

    tick_timer #(.CNT_W(CNT_W)) u_timer (
        .vga_clk (vga_clk),
        .rst     (rst),
        .en      (run),
        .load    (start_go || fire),
        .load_val(load_val),
        .expired (expired)
    );

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            game_tick  <= 1'b0;
            game_reset <= 1'b0;
            busy       <= 1'b0;
            score      <= '0;
            level      <= '0;
            food_cnt   <= '0;
        end else begin
            game_tick  <= fire;
            game_reset <= start_go;
            if (start_go) begin
                busy     <= 1'b0;
                score    <= '0;
                level    <= '0;
                food_cnt <= '0;
            end else begin
                if (fire)
                    busy <= 1'b1;
                else if (ack)
                    busy <= 1'b0;
                if (ack && !collision && food_eaten) begin
                    if (score != 8'hFF)
                        score <= score + 8'd1;
                    if (food_cnt == 8'(FOOD_PER_LEVEL - 1)) begin
                        food_cnt <= '0;
                        if (level != 4'(MAX_LEVEL))
                            level <= level + 4'd1;
                    end else begin
                        food_cnt <= food_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
